// File: rtl/mem_stage_mc.sv
// mem_stage_mc: data-memory stage between EX and WB.
// ALU ops retire in one cycle; memory ops wait on a req/done memory.
//
// Ports:
//   clk, rst (async, active-low)
//   EX side : ex_valid/ex_ready, AluRes, RtIn, RegWriteIn, DMemEnIn,
//             DMemWriteIn, MemToRegIn, DMemDumpIn, RdAddrIn
//   memory  : mem_req/mem_done, mem_wr, mem_addr, mem_wdata, mem_dump,
//             mem_rdata, mem_err
//   WB side : wb_valid, writeData, RegWriteOut, RdAddrOut,
//             DMemDumpOut, wb_err
// Optional: define MEM_TIMEOUT_EN to abort a WAIT after TIMEOUT cycles.

module mem_stage_mc #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int REG_AW  = 3,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] AluRes,
  input  logic [DATA_W-1:0] RtIn,
  input  logic              RegWriteIn,
  input  logic              DMemEnIn,
  input  logic              DMemWriteIn,
  input  logic              MemToRegIn,
  input  logic              DMemDumpIn,
  input  logic [REG_AW-1:0] RdAddrIn,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_dump,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_err,
  output logic              wb_valid,
  output logic [DATA_W-1:0] writeData,
  output logic              RegWriteOut,
  output logic [REG_AW-1:0] RdAddrOut,
  output logic              DMemDumpOut,
  output logic              wb_err
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] rt;
    logic              rw;
    logic              en;
    logic              wr;
    logic              m2r;
    logic              dump;
    logic [REG_AW-1:0] rd;
  } op_t;

  state_t            state_q, state_d;
  op_t               op_q, op_d;
  logic              wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              regw_q, regw_d;
  logic [REG_AW-1:0] rd_out_q, rd_out_d;
  logic              dump_out_q, dump_out_d;
  logic              err_q, err_d;
  logic              timeout;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  // Fires on the WAIT cycle whose count would reach TIMEOUT;
  // a coincident mem_done takes priority.
  assign timeout = (state_q == WAIT) && !mem_done &&
                   (cnt_q == CW'(TIMEOUT - 1));
`else
  assign timeout = 1'b0;
`endif

  assign ex_ready    = (state_q == IDLE);
  assign mem_req     = (state_q == WAIT);
  assign mem_wr      = mem_req & op_q.wr & op_q.en;
  assign mem_dump    = mem_req & op_q.dump;
  assign mem_addr    = op_q.alu[ADDR_W-1:0];
  assign mem_wdata   = op_q.rt;

  assign wb_valid    = wb_valid_q;
  assign writeData   = wdata_q;
  assign RegWriteOut = regw_q;
  assign RdAddrOut   = rd_out_q;
  assign DMemDumpOut = dump_out_q;
  assign wb_err      = err_q;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    wb_valid_d = 1'b0;
    regw_d     = 1'b0;
    wdata_d    = wdata_q;
    rd_out_d   = rd_out_q;
    dump_out_d = dump_out_q;
    err_d      = err_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (ex_valid) begin
          if (DMemEnIn || DMemDumpIn) begin
            op_d.alu  = AluRes;
            op_d.rt   = RtIn;
            op_d.rw   = RegWriteIn;
            op_d.en   = DMemEnIn;
            op_d.wr   = DMemWriteIn;
            op_d.m2r  = MemToRegIn;
            op_d.dump = DMemDumpIn;
            op_d.rd   = RdAddrIn;
            state_d   = WAIT;
`ifdef MEM_TIMEOUT_EN
            cnt_d     = '0;
`endif
          end else begin
            wb_valid_d = 1'b1;
            wdata_d    = AluRes;
            regw_d     = RegWriteIn;
            rd_out_d   = RdAddrIn;
            dump_out_d = 1'b0;
            err_d      = 1'b0;
          end
        end
      end
      WAIT: begin
        unique case (1'b1)
          mem_done: begin
            state_d    = IDLE;
            wb_valid_d = 1'b1;
            wdata_d    = op_q.m2r ? mem_rdata : op_q.alu;
            regw_d     = op_q.rw & ~mem_err;
            rd_out_d   = op_q.rd;
            dump_out_d = op_q.dump;
            err_d      = mem_err;
          end
          timeout: begin
            state_d    = IDLE;
            wb_valid_d = 1'b1;
            wdata_d    = op_q.alu;
            regw_d     = 1'b0;
            rd_out_d   = op_q.rd;
            dump_out_d = op_q.dump;
            err_d      = 1'b1;
          end
          default: begin
`ifdef MEM_TIMEOUT_EN
            cnt_d = cnt_q + 1'b1;
`endif
          end
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      op_q       <= '0;
      wb_valid_q <= 1'b0;
      wdata_q    <= '0;
      regw_q     <= 1'b0;
      rd_out_q   <= '0;
      dump_out_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      wb_valid_q <= wb_valid_d;
      wdata_q    <= wdata_d;
      regw_q     <= regw_d;
      rd_out_q   <= rd_out_d;
      dump_out_q <= dump_out_d;
      err_q      <= err_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
`endif

endmodule

// File: tb/tb_mem_stage_mc.sv
// tb_mem_stage_mc: directed + random bench for mem_stage_mc.
// Expected values come from a transaction-level model of the stage.

module tb_mem_stage_mc;

  localparam int DW = 16;
  localparam int AW = 12;
  localparam int RW = 3;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ex_valid = 1'b0;
  logic          ex_ready;
  logic [DW-1:0] AluRes = '0;
  logic [DW-1:0] RtIn = '0;
  logic          RegWriteIn = 1'b0;
  logic          DMemEnIn = 1'b0;
  logic          DMemWriteIn = 1'b0;
  logic          MemToRegIn = 1'b0;
  logic          DMemDumpIn = 1'b0;
  logic [RW-1:0] RdAddrIn = '0;
  logic          mem_req, mem_wr, mem_dump;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_done = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_err = 1'b0;
  logic          wb_valid;
  logic [DW-1:0] writeData;
  logic          RegWriteOut;
  logic [RW-1:0] RdAddrOut;
  logic          DMemDumpOut;
  logic          wb_err;

  mem_stage_mc #(
    .DATA_W(DW), .ADDR_W(AW), .REG_AW(RW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .AluRes(AluRes), .RtIn(RtIn),
    .RegWriteIn(RegWriteIn), .DMemEnIn(DMemEnIn),
    .DMemWriteIn(DMemWriteIn), .MemToRegIn(MemToRegIn),
    .DMemDumpIn(DMemDumpIn), .RdAddrIn(RdAddrIn),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_dump(mem_dump),
    .mem_done(mem_done), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .wb_valid(wb_valid), .writeData(writeData),
    .RegWriteOut(RegWriteOut), .RdAddrOut(RdAddrOut),
    .DMemDumpOut(DMemDumpOut), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // Model: one outstanding memory op, plus the last WB result.
  bit          m_busy = 0;
  int          m_wcnt = 0;
  logic [DW-1:0] p_alu, p_rt;
  bit          p_rw, p_en, p_wr, p_m2r, p_dump;
  logic [RW-1:0] p_rd;
  bit          m_wv = 0;
  logic [DW-1:0] m_data;
  bit          m_regw, m_dump, m_err;
  logic [RW-1:0] m_rd;

  task automatic check_outputs();
    check("ex_ready", 32'(ex_ready), 32'(!m_busy));
    check("mem_req", 32'(mem_req), 32'(m_busy));
    if (m_busy) begin
      check("mem_addr", 32'(mem_addr), 32'(p_alu % (1 << AW)));
      check("mem_wr", 32'(mem_wr), 32'(p_wr && p_en));
      check("mem_wdata", 32'(mem_wdata), 32'(p_rt));
      check("mem_dump", 32'(mem_dump), 32'(p_dump));
    end else begin
      check("mem_wr_idle", 32'(mem_wr), 32'd0);
      check("mem_dump_idle", 32'(mem_dump), 32'd0);
    end
    check("wb_valid", 32'(wb_valid), 32'(m_wv));
    if (m_wv) begin
      check("writeData", 32'(writeData), 32'(m_data));
      check("RegWriteOut", 32'(RegWriteOut), 32'(m_regw));
      check("RdAddrOut", 32'(RdAddrOut), 32'(m_rd));
      check("DMemDumpOut", 32'(DMemDumpOut), 32'(m_dump));
      check("wb_err", 32'(wb_err), 32'(m_err));
    end else begin
      check("RegWriteOut_idle", 32'(RegWriteOut), 32'd0);
    end
  endtask

  // Check the results of the previous cycle, then apply new inputs
  // and advance the model by one clock.
  task automatic step(input bit v, input logic [DW-1:0] alu,
                      input logic [DW-1:0] rt, input bit rw,
                      input bit en, input bit wr, input bit m2r,
                      input bit dump, input logic [RW-1:0] rd,
                      input bit done, input logic [DW-1:0] rdata,
                      input bit err);
    bit handled;
    @(negedge clk);
    check_outputs();
    ex_valid = v; AluRes = alu; RtIn = rt; RegWriteIn = rw;
    DMemEnIn = en; DMemWriteIn = wr; MemToRegIn = m2r;
    DMemDumpIn = dump; RdAddrIn = rd;
    mem_done = done; mem_rdata = rdata; mem_err = err;
    m_wv = 0;
    if (m_busy) begin
      m_wcnt++;
      handled = 0;
      if (done) begin
        m_busy = 0; m_wv = 1;
        m_data = p_m2r ? rdata : p_alu;
        m_regw = p_rw && !err;
        m_rd = p_rd; m_dump = p_dump; m_err = err;
        handled = 1;
      end
`ifdef MEM_TIMEOUT_EN
      if (!handled && m_wcnt == TO) begin
        m_busy = 0; m_wv = 1;
        m_data = p_alu; m_regw = 0;
        m_rd = p_rd; m_dump = p_dump; m_err = 1;
      end
`endif
    end else if (v) begin
      if (en || dump) begin
        m_busy = 1; m_wcnt = 0;
        p_alu = alu; p_rt = rt; p_rw = rw; p_en = en; p_wr = wr;
        p_m2r = m2r; p_dump = dump; p_rd = rd;
      end else begin
        m_wv = 1; m_data = alu; m_regw = rw; m_rd = rd;
        m_dump = 0; m_err = 0;
      end
    end
  endtask

  task automatic idle(input bit done, input logic [DW-1:0] rdata,
                      input bit err);
    step(0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 3'd0, done, rdata, err);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // reset state visible on the first idle step
    idle(0, 0, 0);

    // ALU passthrough, back to back
    step(1, 16'h0011, 16'h0, 1, 0, 0, 0, 0, 3'd1, 0, 0, 0);
    step(1, 16'h0022, 16'h0, 1, 0, 0, 0, 0, 3'd2, 0, 0, 0);
    step(1, 16'h0033, 16'h0, 1, 0, 0, 0, 0, 3'd3, 0, 0, 0);
    idle(0, 0, 0);

    // load, memory answers on the third WAIT cycle
    step(1, 16'h0040, 16'h0, 1, 1, 0, 1, 0, 3'd5, 0, 0, 0);
    idle(0, 0, 0);
    idle(0, 0, 0);
    idle(1, 16'hBEEF, 0);
    idle(0, 0, 0);

    // store done next cycle, then faulting load
    step(1, 16'h0010, 16'h1234, 0, 1, 1, 0, 0, 3'd0, 0, 0, 0);
    idle(1, 16'h0, 0);
    step(1, 16'h0011, 16'h0, 1, 1, 0, 1, 0, 3'd4, 0, 0, 0);
    idle(1, 16'h5555, 1);
    idle(0, 0, 0);

    // upper AluRes bits ignored for address, kept as data
    step(1, 16'hF123, 16'h0, 1, 1, 0, 0, 0, 3'd6, 0, 0, 0);
    idle(1, 16'h0, 0);
    idle(1, 16'h0, 0);

    // reset two cycles into a load
    step(1, 16'h0080, 16'h0, 1, 1, 0, 1, 0, 3'd7, 0, 0, 0);
    idle(0, 0, 0);
    idle(0, 0, 0);
    #2;
    check("mem_req_pre_rst", 32'(mem_req), 32'd1);
    rst = 1'b0;
    #1;
    check("mem_req_async_drop", 32'(mem_req), 32'd0);
    m_busy = 0; m_wv = 0;
    @(negedge clk);
    rst = 1'b1;
    idle(1, 16'hAAAA, 0);
    idle(0, 0, 0);
    idle(0, 0, 0);

`ifdef MEM_TIMEOUT_EN
    // memory never answers
    step(1, 16'h0020, 16'h0, 1, 1, 0, 1, 0, 3'd2, 0, 0, 0);
    for (int i = 0; i < 6; i++) idle(0, 0, 0);
`endif

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(3) != 0,
           16'($urandom), 16'($urandom),
           $urandom_range(1) == 1,
           $urandom_range(1) == 1,
           $urandom_range(1) == 1,
           $urandom_range(1) == 1,
           $urandom_range(7) == 0,
           3'($urandom),
           $urandom_range(2) == 0,
           16'($urandom),
           $urandom_range(4) == 0);
    end
    idle(1, 0, 0);
    idle(0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
